timer_prescaler: RTL and testbench

- Generates the six prescaled timing references (phi/2, phi/8, phi/32, phi/64, phi/1024, phi/8192) that the timer clock-select logic consumes as its internal count sources.
- Built around one free-running 13-bit divide counter clocked by the peripheral clock, with synchronous clear and count-enable controls.
- Outputs are registered 50 %-duty divided levels, so the downstream rising/falling/both-edge selection works on them directly.
- Sits between the APB timer register block (clear/enable control) and the clock-select stage.

---
 rtl/timer_prescaler_pkg.sv | 33 +++
 rtl/prescaler_tap.sv | 48 ++++
 rtl/timer_prescaler.sv | 91 +++++++++
 tb/tb_timer_prescaler.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/timer_prescaler_pkg.sv
// timer_prescaler_pkg: shared constants and types for the timer prescaler.
// Holds the default divide-counter width, the tap bit indices of the six
// prescaled references and the packed tap vector type.
package timer_prescaler_pkg;

    localparam int CNT_W_DEF = 13;
    localparam int TAP_NUM   = 6;

    // Counter bit that carries phi/N is log2(N)-1
    localparam int TAP_PHI_2    = 0;
    localparam int TAP_PHI_8    = 2;
    localparam int TAP_PHI_32   = 4;
    localparam int TAP_PHI_64   = 5;
    localparam int TAP_PHI_1024 = 9;
    localparam int TAP_PHI_8192 = 12;

    // Bit order: [0]=phi/2 [1]=phi/8 [2]=phi/32 [3]=phi/64 [4]=phi/1024 [5]=phi/8192
    typedef logic [TAP_NUM-1:0] tap_vec_t;

    // Maps a tap vector position to the counter bit that feeds it
    function automatic int tap_bit(input int idx);
        case (idx)
            0:       tap_bit = TAP_PHI_2;
            1:       tap_bit = TAP_PHI_8;
            2:       tap_bit = TAP_PHI_32;
            3:       tap_bit = TAP_PHI_64;
            4:       tap_bit = TAP_PHI_1024;
            5:       tap_bit = TAP_PHI_8192;
            default: tap_bit = TAP_PHI_2;
        endcase
    endfunction

endpackage

// File: rtl/prescaler_tap.sv
// prescaler_tap: one registered divided level taken from a divide-counter bit.
// The level register follows the counter bit, so it always equals the
// counter bit of the current cycle. With TIMER_PRESCALER_PULSE_OUT_EN
// defined a registered single-cycle pulse marks each rising edge.
module prescaler_tap (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_nxt,
    input  logic i_cur,
`ifdef TIMER_PRESCALER_PULSE_OUT_EN
    output logic o_pls,
`endif
    output logic o_lvl
);

    logic w_chg;
    logic r_lvl;

    assign w_chg = i_nxt ^ i_cur;
    assign o_lvl = r_lvl;

    // Level register: takes the new counter bit whenever it changes
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_lvl <= 1'b0;
        end else if (w_chg) begin
            r_lvl <= i_nxt;
        end else begin
            r_lvl <= r_lvl;
        end
    end

`ifdef TIMER_PRESCALER_PULSE_OUT_EN
    logic r_pls;

    assign o_pls = r_pls;

    // Pulse register: high in the cycle the level first shows 1 after a 0
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pls <= 1'b0;
        end else begin
            r_pls <= w_chg & i_nxt;
        end
    end
`endif

endmodule

// File: rtl/timer_prescaler.sv
// timer_prescaler: free-running divide counter producing the six prescaled
// timing references (phi/2 .. phi/8192) used as timer count sources.
// Optional feature macro: TIMER_PRESCALER_PULSE_OUT_EN adds registered
// rising-edge pulse outputs o_pls_phi_*.
module timer_prescaler
    import timer_prescaler_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_en,
    input  logic             i_clr,
    output logic             o_clk_phi_2,
    output logic             o_clk_phi_8,
    output logic             o_clk_phi_32,
    output logic             o_clk_phi_64,
    output logic             o_clk_phi_1024,
    output logic             o_clk_phi_8192,
`ifdef TIMER_PRESCALER_PULSE_OUT_EN
    output logic             o_pls_phi_2,
    output logic             o_pls_phi_8,
    output logic             o_pls_phi_32,
    output logic             o_pls_phi_64,
    output logic             o_pls_phi_1024,
    output logic             o_pls_phi_8192,
`endif
    output logic [CNT_W-1:0] o_presc_cnt
);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    tap_vec_t         w_lvl;

    // Counter next state: clear beats enable, otherwise hold
    always_comb begin
        w_cnt_nxt = r_cnt;
        if (i_clr) begin
            w_cnt_nxt = {CNT_W{1'b0}};
        end else if (i_en) begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
        end else begin
            w_cnt_nxt = r_cnt;
        end
    end

    // Divide counter register; wraps silently from all-ones to zero
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= {CNT_W{1'b0}};
        end else begin
            r_cnt <= w_cnt_nxt;
        end
    end

`ifdef TIMER_PRESCALER_PULSE_OUT_EN
    tap_vec_t w_pls;
`endif

    for (genvar g = 0; g < TAP_NUM; g++) begin : g_tap
        localparam int TAP_BIT = tap_bit(g);
        prescaler_tap u_tap (
            .i_clk   (i_clk),
            .i_rst_n (i_rst_n),
            .i_nxt   (w_cnt_nxt[TAP_BIT]),
            .i_cur   (r_cnt[TAP_BIT]),
`ifdef TIMER_PRESCALER_PULSE_OUT_EN
            .o_pls   (w_pls[g]),
`endif
            .o_lvl   (w_lvl[g])
        );
    end

    assign o_presc_cnt    = r_cnt;
    assign o_clk_phi_2    = w_lvl[0];
    assign o_clk_phi_8    = w_lvl[1];
    assign o_clk_phi_32   = w_lvl[2];
    assign o_clk_phi_64   = w_lvl[3];
    assign o_clk_phi_1024 = w_lvl[4];
    assign o_clk_phi_8192 = w_lvl[5];

`ifdef TIMER_PRESCALER_PULSE_OUT_EN
    assign o_pls_phi_2    = w_pls[0];
    assign o_pls_phi_8    = w_pls[1];
    assign o_pls_phi_32   = w_pls[2];
    assign o_pls_phi_64   = w_pls[3];
    assign o_pls_phi_1024 = w_pls[4];
    assign o_pls_phi_8192 = w_pls[5];
`endif

endmodule

// File: tb/tb_timer_prescaler.sv
// tb_timer_prescaler: self-checking bench for timer_prescaler.
// Reference model: an integer count updated by the clear/enable rules; each
// tap level is (cnt / (N/2)) % 2 and each pulse is "count just advanced onto
// cnt % N == N/2".
module tb_timer_prescaler;

    localparam int CNT_W = 13;
    localparam int MOD   = 8192;

    logic             i_clk;
    logic             i_rst_n;
    logic             i_en;
    logic             i_clr;
    logic             o_clk_phi_2, o_clk_phi_8, o_clk_phi_32;
    logic             o_clk_phi_64, o_clk_phi_1024, o_clk_phi_8192;
    logic [CNT_W-1:0] o_presc_cnt;
`ifdef TIMER_PRESCALER_PULSE_OUT_EN
    logic             o_pls_phi_2, o_pls_phi_8, o_pls_phi_32;
    logic             o_pls_phi_64, o_pls_phi_1024, o_pls_phi_8192;
`endif

    timer_prescaler #(.CNT_W(CNT_W)) dut (
        .i_clk          (i_clk),
        .i_rst_n        (i_rst_n),
        .i_en           (i_en),
        .i_clr          (i_clr),
        .o_clk_phi_2    (o_clk_phi_2),
        .o_clk_phi_8    (o_clk_phi_8),
        .o_clk_phi_32   (o_clk_phi_32),
        .o_clk_phi_64   (o_clk_phi_64),
        .o_clk_phi_1024 (o_clk_phi_1024),
        .o_clk_phi_8192 (o_clk_phi_8192),
`ifdef TIMER_PRESCALER_PULSE_OUT_EN
        .o_pls_phi_2    (o_pls_phi_2),
        .o_pls_phi_8    (o_pls_phi_8),
        .o_pls_phi_32   (o_pls_phi_32),
        .o_pls_phi_64   (o_pls_phi_64),
        .o_pls_phi_1024 (o_pls_phi_1024),
        .o_pls_phi_8192 (o_pls_phi_8192),
`endif
        .o_presc_cnt    (o_presc_cnt)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int checks   = 0;
    int failures = 0;
    int m_cnt    = 0;
    bit m_adv    = 1'b0;
    int divs [6] = '{2, 8, 32, 64, 1024, 8192};

    int      rise_1024 = 0;
    int      pls_64_n  = 0;
    int      pls_8_n   = 0;
    logic    prev_1024 = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [5:0] dut_lvl();
        return {o_clk_phi_8192, o_clk_phi_1024, o_clk_phi_64,
                o_clk_phi_32, o_clk_phi_8, o_clk_phi_2};
    endfunction

    function automatic logic [5:0] exp_lvl();
        logic [5:0] v;
        for (int i = 0; i < 6; i++) v[i] = ((m_cnt / (divs[i] / 2)) % 2) == 1;
        return v;
    endfunction

`ifdef TIMER_PRESCALER_PULSE_OUT_EN
    function automatic logic [5:0] dut_pls();
        return {o_pls_phi_8192, o_pls_phi_1024, o_pls_phi_64,
                o_pls_phi_32, o_pls_phi_8, o_pls_phi_2};
    endfunction

    function automatic logic [5:0] exp_pls();
        logic [5:0] v;
        for (int i = 0; i < 6; i++) v[i] = m_adv && ((m_cnt % divs[i]) == (divs[i] / 2));
        return v;
    endfunction
`endif

    task automatic check_all(input string tag);
        check_eq({tag, ".cnt"}, 32'(o_presc_cnt), 32'(m_cnt));
        check_eq({tag, ".lvl"}, 32'(dut_lvl()), 32'(exp_lvl()));
`ifdef TIMER_PRESCALER_PULSE_OUT_EN
        check_eq({tag, ".pls"}, 32'(dut_pls()), 32'(exp_pls()));
`endif
    endtask

    // One clock: drive at negedge, model update at posedge, check 1 time unit later
    task automatic step(input logic en, input logic clr, input string tag);
        i_en  = en;
        i_clr = clr;
        @(posedge i_clk);
        if (clr) begin
            m_cnt = 0;
            m_adv = 1'b0;
        end else if (en) begin
            m_cnt = (m_cnt + 1) % MOD;
            m_adv = 1'b1;
        end else begin
            m_adv = 1'b0;
        end
        #1;
        check_all(tag);
        if (o_clk_phi_1024 && !prev_1024) rise_1024++;
        prev_1024 = o_clk_phi_1024;
`ifdef TIMER_PRESCALER_PULSE_OUT_EN
        if (o_pls_phi_64) pls_64_n++;
        if (o_pls_phi_8)  pls_8_n++;
`endif
        @(negedge i_clk);
    endtask

    task automatic run_to(input int target, input string tag);
        int n;
        n = 0;
        while (m_cnt != target && n < 9000) begin
            step(1'b1, 1'b0, tag);
            n++;
        end
        check_eq({tag, ".reached"}, 32'(m_cnt), 32'(target));
    endtask

    initial begin
        i_rst_n = 1'b0;
        i_en    = 1'b0;
        i_clr   = 1'b0;
        #3;
        check_all("reset");
        @(negedge i_clk);
        i_rst_n = 1'b1;

        // First 16 enabled cycles after reset
        for (int k = 0; k < 16; k++) step(1'b1, 1'b0, "first16");
        check_eq("first16.cnt16", 32'(o_presc_cnt), 32'd16);

        // Full wrap: phi/1024 must complete exactly 8 periods
        rise_1024 = 0;
        prev_1024 = o_clk_phi_1024;
        for (int k = 0; k < MOD; k++) step(1'b1, 1'b0, "wrap");
        check_eq("wrap.rise1024", 32'(rise_1024), 32'd8);

        // Freeze at 37 for 10 cycles, then resume to 48
        run_to(37, "to37");
        for (int k = 0; k < 10; k++) step(1'b0, 1'b0, "freeze");
        run_to(48, "resume");
        check_eq("resume.phi32", 32'(o_clk_phi_32), 32'd1);

        // Randomised enable/clear traffic
        for (int k = 0; k < 2000; k++)
            step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 63) == 0), "rand");

        // Clear together with enable at 700
        step(1'b0, 1'b1, "preclr");
        run_to(700, "to700");
        step(1'b1, 1'b1, "clr_en");
        check_eq("clr_en.taps", 32'(dut_lvl()), 32'd0);
        step(1'b1, 1'b0, "after_clr");
        check_eq("after_clr.cnt1", 32'(o_presc_cnt), 32'd1);

`ifdef TIMER_PRESCALER_PULSE_OUT_EN
        // 128 enabled cycles from clear: pulse counts, then idle with en low
        step(1'b0, 1'b1, "pls_clr");
        pls_64_n = 0;
        pls_8_n  = 0;
        for (int k = 0; k < 128; k++) step(1'b1, 1'b0, "pls_run");
        check_eq("pls.n64", 32'(pls_64_n), 32'd2);
        check_eq("pls.n8", 32'(pls_8_n), 32'd16);
        for (int k = 0; k < 8; k++) step(1'b0, 1'b0, "pls_idle");
        check_eq("pls.idle_n8", 32'(pls_8_n), 32'd16);
`endif

        // Asynchronous reset between clock edges at 5000
        run_to(5000, "to5000");
        @(posedge i_clk);
        #3;
        i_rst_n = 1'b0;
        #1;
        m_cnt = 0;
        m_adv = 1'b0;
        check_all("async_rst");
        @(negedge i_clk);
        i_rst_n = 1'b1;
        for (int k = 0; k < 6; k++) step(1'b1, 1'b0, "post_rst");
        check_eq("post_rst.cnt6", 32'(o_presc_cnt), 32'd6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
